reservation_station: RTL and testbench
======================================

Name: reservation_station

Overview:
- Out-of-order ALU reservation station; issuing side of the RS→FU interface (RS_valid/RS_op/RS_Vj/RS_Vk/RS_Imm/RS_DestRob/RS_CurPC).
- Buffers dispatched ALU/branch/jump ops and snoops both CDBs (ALU broadcast, LSB broadcast) to wake pending operands.
- Each cycle, issues at most one ready entry to the combinational FU.

Parameters:
- RS_SIZE, 16, number of entries (power of two).
- RS_LOG, 4, log2(RS_SIZE).
- OP_LOG, 6, opcode width; shared `OP_*` encoding.
- ROB_LOG, 4, ROB tag width.

Ports:
- clk_in  in  1  clock; all state updates on posedge.
- rst_in  in  1  reset, asynchronous, active-low.
- rdy_in  in  1  global ready; 0 = freeze.
- clear_in  in  1  ROB mispredict flush, synchronous.
- D_valid  in  1  dispatch request.
- D_op  in  OP_LOG  opcode.
- D_Qj_busy, D_Qk_busy  in  1 each  operand waits on a ROB tag.
- D_Qj, D_Qk  in  ROB_LOG each  producer tags.
- D_Vj, D_Vk, D_Imm, D_CurPC  in  32 each  operand values, immediate, PC.
- D_DestRob  in  ROB_LOG  destination tag.
- B_enable  in  1  ALU CDB valid.
- B_RobId  in  ROB_LOG  ALU CDB tag.
- B_value  in  32  ALU CDB value.
- L_enable, L_RobId, L_value  in  1/ROB_LOG/32  LSB CDB.
- RS_full  out  1  no free entry (combinational from state).
- RS_valid  out  1  issue strobe to FU.
- RS_op  out  OP_LOG  issued opcode.
- RS_Vj, RS_Vk, RS_Imm, RS_CurPC  out  32 each  issued operands, immediate, PC.
- RS_DestRob  out  ROB_LOG  issued destination tag.

Behaviour:
- Reset (rst_in=0, async): all entries busy=0; all RS_* outputs registered and cleared to 0; RS_full=0.
- Entry fields: busy, op, Qj_busy, Qj, Vj, Qk_busy, Qk, Vk, Imm, DestRob, CurPC.
- Wakeup (each edge, rdy_in=1): for every busy entry with Qx_busy and Qx==B_RobId && B_enable → Vx=B_value, Qx_busy=0. LSB CDB is handled identically. If both buses match the same tag (illegal), the ALU CDB wins.
- Dispatch: if D_valid && !RS_full, write to the lowest-index free entry.
  - Same-cycle bypass: if an incoming Qx matches an active CDB tag, store the bus value with Qx_busy=0.
  - D_valid while RS_full → dropped silently; this is a dispatcher protocol violation.
- Ready: busy && !Qj_busy && !Qk_busy.
- Issue: select the lowest-index ready entry from pre-edge state; register its fields onto RS_*; set RS_valid=1 and clear the entry's busy on the same edge. Latency is one cycle.
  - If no entry is ready, RS_valid=0 next cycle and the other RS_* outputs hold.
  - An entry dispatched this cycle cannot issue this cycle; earliest issue is the next cycle, visible on RS_valid one cycle after that.
  - An entry woken by the CDB this edge becomes eligible next cycle.
- Free slot choice uses pre-edge state: a slot freed by issue on edge N is allocatable from edge N+1. RS_full = all busy.
- Simultaneous dispatch + issue + wakeup in one cycle is legal; these act on disjoint entries by construction.
- clear_in=1 (with rdy_in=1): all busy=0 and RS_valid=0 at the edge. Same-cycle dispatch and issue are discarded. Takes priority over everything except reset.
- rdy_in=0: entries frozen and no dispatch/wakeup/issue; RS_valid forced 0 at the edge so the FU does not re-broadcast. CDB events during freeze are lost; the ROB/CDB are frozen too.
- Reset mid-operation: all state lost immediately, outputs 0 asynchronously.
- Opcode is not interpreted. OP_NOP, if dispatched, issues normally (FU ignores it).

Decomposition:
- Shared config header holds `OP_LOG`, `ROB_LOG`, `RS_SIZE`, `RS_LOG` and the `OP_*` opcode codes, already used by the FU/decoder.
- One sub-module: rs_select. It is a parameterised lowest-index priority encoder (RS_SIZE-bit request vector → found flag + RS_LOG index). It is instantiated twice: free-slot search and ready-entry search.

Test Plan:
- Ready dispatch: D_op=OP_ADD, Vj=5, Vk=7, DestRob=3, no Q busy, at cycle 0 → RS_valid=1 at cycle 2 with Vj=5, Vk=7, DestRob=3; entry freed.
- CDB wakeup: dispatch with Qj_busy, Qj=6; then B_enable, B_RobId=6, B_value=0x1234 → next cycle RS_valid, RS_Vj=0x1234. LSB bus tag 6 gives the same result.
- Same-cycle bypass: dispatch with Qk=2 while L_enable, L_RobId=2, L_value=0xDEAD → stored ready; RS_Vk=0xDEAD on issue.
- Full/ordering: fill 16 blocked entries → RS_full=1; extra dispatch dropped (count stays 16). Wake entries 9 and 4 together → 4 issues before 9; RS_full falls after the first issue.
- Flush: 5 busy entries plus a pending issue, clear_in=1 → next cycle RS_valid=0, RS_full=0, no issues for 3 cycles; a dispatch asserted in the clear cycle is absent.
- Freeze/reset: rdy_in=0 with a ready entry → RS_valid=0 and entry retained; rdy_in=1 → issues. Assert rst_in=0 mid-cycle → RS_valid=0 immediately.

Source files
------------

// File: rtl/reservation_station_pkg.sv
// Shared configuration for the ALU reservation station slice.
//   - Sizing constants (RS_SIZE/RS_LOG, OP_LOG, ROB_LOG) used by the
//     decoder, FU and reservation station.
//   - OP_* opcode codes (opaque to the reservation station).
//   - Operand / CDB / entry record types and the CDB snoop helper used for
//     both wakeup of stored entries and same-cycle dispatch bypass.
package reservation_station_pkg;

  localparam int RS_SIZE = 16;
  localparam int RS_LOG  = 4;
  localparam int OP_LOG  = 6;
  localparam int ROB_LOG = 4;

  localparam logic [OP_LOG-1:0] OP_NOP = 6'd0;
  localparam logic [OP_LOG-1:0] OP_ADD = 6'd1;
  localparam logic [OP_LOG-1:0] OP_SUB = 6'd2;
  localparam logic [OP_LOG-1:0] OP_BEQ = 6'd3;
  localparam logic [OP_LOG-1:0] OP_JAL = 6'd4;

  // One source operand: either waiting on a ROB tag or holding its value.
  typedef struct packed {
    logic               busy;
    logic [ROB_LOG-1:0] tag;
    logic [31:0]        value;
  } operand_t;

  // One common-data-bus broadcast.
  typedef struct packed {
    logic               enable;
    logic [ROB_LOG-1:0] rob_id;
    logic [31:0]        value;
  } cdb_t;

  // Payload of one reservation-station slot (occupancy is kept separately).
  typedef struct packed {
    logic [OP_LOG-1:0]  op;
    operand_t           j;
    operand_t           k;
    logic [31:0]        imm;
    logic [ROB_LOG-1:0] dest_rob;
    logic [31:0]        cur_pc;
  } rs_entry_t;

  // Capture a broadcast value into a waiting operand. The ALU bus is checked
  // first so it wins if both buses (illegally) carry the same tag.
  function automatic operand_t snoop(operand_t opnd, cdb_t alu, cdb_t lsb);
    operand_t res;
    res = opnd;
    if (opnd.busy) begin
      if (alu.enable && alu.rob_id == opnd.tag) begin
        res.busy  = 1'b0;
        res.value = alu.value;
      end else if (lsb.enable && lsb.rob_id == opnd.tag) begin
        res.busy  = 1'b0;
        res.value = lsb.value;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/reservation_station_select.sv
// rs_select: lowest-index priority encoder.
//   req   in  N  request vector
//   found out 1  any request set
//   idx   out W  index of the lowest set request (0 when none)
module rs_select #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [W-1:0] idx
);

  always_comb begin
    found = |req;
    idx   = '0;
    // NOTE: blocking assignments in a descending scan; the last hit written
    // is the lowest index, which is the one we want.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/reservation_station.sv
// reservation_station: out-of-order ALU reservation station.
// Buffers dispatched ops, snoops the ALU and LSB CDBs to wake operands, and
// issues at most one ready entry per cycle to the combinational FU.
//   clk_in, rst_in (async, active-low), rdy_in (0 = freeze), clear_in (flush)
//   D_*   dispatch request: opcode, operand tags/values, imm, dest tag, PC
//   B_*   ALU CDB broadcast;  L_* LSB CDB broadcast
//   RS_full  no free entry (combinational from state)
//   RS_*     registered issue bundle to the FU, RS_valid is the strobe
module reservation_station
  import reservation_station_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               clear_in,
  input  logic               D_valid,
  input  logic [OP_LOG-1:0]  D_op,
  input  logic               D_Qj_busy,
  input  logic               D_Qk_busy,
  input  logic [ROB_LOG-1:0] D_Qj,
  input  logic [ROB_LOG-1:0] D_Qk,
  input  logic [31:0]        D_Vj,
  input  logic [31:0]        D_Vk,
  input  logic [31:0]        D_Imm,
  input  logic [31:0]        D_CurPC,
  input  logic [ROB_LOG-1:0] D_DestRob,
  input  logic               B_enable,
  input  logic [ROB_LOG-1:0] B_RobId,
  input  logic [31:0]        B_value,
  input  logic               L_enable,
  input  logic [ROB_LOG-1:0] L_RobId,
  input  logic [31:0]        L_value,
  output logic               RS_full,
  output logic               RS_valid,
  output logic [OP_LOG-1:0]  RS_op,
  output logic [31:0]        RS_Vj,
  output logic [31:0]        RS_Vk,
  output logic [31:0]        RS_Imm,
  output logic [31:0]        RS_CurPC,
  output logic [ROB_LOG-1:0] RS_DestRob
);

  logic [RS_SIZE-1:0] busy_q;
  rs_entry_t          ent_q [RS_SIZE];
  rs_entry_t          ent_d [RS_SIZE];
  rs_entry_t          disp_entry;
  cdb_t               alu_cdb;
  cdb_t               lsb_cdb;
  logic [RS_SIZE-1:0] ready_vec;
  logic               free_found;
  logic               issue_found;
  logic [RS_LOG-1:0]  free_idx;
  logic [RS_LOG-1:0]  issue_idx;
  logic               do_disp;
  logic               do_issue;

  assign alu_cdb = '{enable: B_enable, rob_id: B_RobId, value: B_value};
  assign lsb_cdb = '{enable: L_enable, rob_id: L_RobId, value: L_value};

  // Readiness is taken from pre-edge state, so an entry woken or dispatched
  // this cycle only becomes eligible on the following cycle.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ready_vec[i] = busy_q[i] & ~ent_q[i].j.busy & ~ent_q[i].k.busy;
    end
  end

  rs_select #(.N(RS_SIZE), .W(RS_LOG)) u_free_sel (
    .req   (~busy_q),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_select #(.N(RS_SIZE), .W(RS_LOG)) u_issue_sel (
    .req   (ready_vec),
    .found (issue_found),
    .idx   (issue_idx)
  );

  assign RS_full  = ~free_found;
  assign do_disp  = rdy_in & ~clear_in & D_valid & free_found;
  assign do_issue = rdy_in & ~clear_in & issue_found;

  // Incoming operands also snoop the buses so a producer broadcasting in the
  // dispatch cycle is not missed.
  assign disp_entry = '{
    op:       D_op,
    j:        snoop(operand_t'{D_Qj_busy, D_Qj, D_Vj}, alu_cdb, lsb_cdb),
    k:        snoop(operand_t'{D_Qk_busy, D_Qk, D_Vk}, alu_cdb, lsb_cdb),
    imm:      D_Imm,
    dest_rob: D_DestRob,
    cur_pc:   D_CurPC
  };

  // Dispatch targets a free slot and wakeup only changes waiting operands, so
  // neither disturbs the entry being issued.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      // NOTE: every entry gets its default first, so no path leaves ent_d
      // unassigned and no latch is inferred.
      ent_d[i]   = ent_q[i];
      ent_d[i].j = snoop(ent_q[i].j, alu_cdb, lsb_cdb);
      ent_d[i].k = snoop(ent_q[i].k, alu_cdb, lsb_cdb);
      if (do_disp && free_idx == RS_LOG'(i)) ent_d[i] = disp_entry;
    end
  end

  // NOTE: the payload array has no reset; a slot's contents are meaningless
  // until its busy bit is set, and only busy_q needs a defined reset value.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      // NOTE: sequential state uses non-blocking assignments throughout.
      ent_q <= ent_d;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q <= '0;
    end else if (rdy_in) begin
      if (clear_in) begin
        busy_q <= '0;
      end else begin
        if (do_issue) busy_q[issue_idx] <= 1'b0;
        if (do_disp)  busy_q[free_idx]  <= 1'b1;
      end
    end
  end

  // Issue register. The strobe drops during freeze or flush so the FU never
  // re-broadcasts a stale result; the payload holds when nothing issues.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      RS_valid   <= 1'b0;
      RS_op      <= '0;
      RS_Vj      <= '0;
      RS_Vk      <= '0;
      RS_Imm     <= '0;
      RS_CurPC   <= '0;
      RS_DestRob <= '0;
    end else begin
      RS_valid <= do_issue;
      if (do_issue) begin
        RS_op      <= ent_q[issue_idx].op;
        RS_Vj      <= ent_q[issue_idx].j.value;
        RS_Vk      <= ent_q[issue_idx].k.value;
        RS_Imm     <= ent_q[issue_idx].imm;
        RS_CurPC   <= ent_q[issue_idx].cur_pc;
        RS_DestRob <= ent_q[issue_idx].dest_rob;
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station. Expected issue bundles are
// pushed to a scoreboard queue when stimulus is driven and compared by a
// negedge monitor whenever RS_valid is seen.
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic               clk_in = 1'b0;
  logic               rst_in, rdy_in, clear_in;
  logic               D_valid, D_Qj_busy, D_Qk_busy;
  logic [OP_LOG-1:0]  D_op;
  logic [ROB_LOG-1:0] D_Qj, D_Qk, D_DestRob;
  logic [31:0]        D_Vj, D_Vk, D_Imm, D_CurPC;
  logic               B_enable, L_enable;
  logic [ROB_LOG-1:0] B_RobId, L_RobId;
  logic [31:0]        B_value, L_value;
  logic               RS_full, RS_valid;
  logic [OP_LOG-1:0]  RS_op;
  logic [31:0]        RS_Vj, RS_Vk, RS_Imm, RS_CurPC;
  logic [ROB_LOG-1:0] RS_DestRob;

  typedef struct {
    logic [OP_LOG-1:0]  op;
    logic [31:0]        vj, vk, imm, pc;
    logic [ROB_LOG-1:0] dest;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  reservation_station dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .D_valid(D_valid), .D_op(D_op), .D_Qj_busy(D_Qj_busy), .D_Qk_busy(D_Qk_busy),
    .D_Qj(D_Qj), .D_Qk(D_Qk), .D_Vj(D_Vj), .D_Vk(D_Vk), .D_Imm(D_Imm),
    .D_CurPC(D_CurPC), .D_DestRob(D_DestRob),
    .B_enable(B_enable), .B_RobId(B_RobId), .B_value(B_value),
    .L_enable(L_enable), .L_RobId(L_RobId), .L_value(L_value),
    .RS_full(RS_full), .RS_valid(RS_valid), .RS_op(RS_op), .RS_Vj(RS_Vj),
    .RS_Vk(RS_Vk), .RS_Imm(RS_Imm), .RS_CurPC(RS_CurPC), .RS_DestRob(RS_DestRob)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every issue strobe must match the oldest expectation.
  always @(negedge clk_in) begin
    if (rst_in === 1'b1 && RS_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_issue", 32'(RS_DestRob), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("iss_op",   32'(RS_op),      32'(e.op));
        check("iss_vj",   RS_Vj,           e.vj);
        check("iss_vk",   RS_Vk,           e.vk);
        check("iss_imm",  RS_Imm,          e.imm);
        check("iss_pc",   RS_CurPC,        e.pc);
        check("iss_dest", 32'(RS_DestRob), 32'(e.dest));
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    D_valid  = 1'b0;
    B_enable = 1'b0;
    L_enable = 1'b0;
    clear_in = 1'b0;
  endtask

  task automatic disp(input logic [OP_LOG-1:0] op,
                      input logic qjb, input logic [ROB_LOG-1:0] qj, input logic [31:0] vj,
                      input logic qkb, input logic [ROB_LOG-1:0] qk, input logic [31:0] vk,
                      input logic [31:0] imm, input logic [ROB_LOG-1:0] dest,
                      input logic [31:0] pc);
    D_valid = 1'b1; D_op = op;
    D_Qj_busy = qjb; D_Qj = qj; D_Vj = vj;
    D_Qk_busy = qkb; D_Qk = qk; D_Vk = vk;
    D_Imm = imm; D_DestRob = dest; D_CurPC = pc;
  endtask

  task automatic push(input logic [OP_LOG-1:0] op, input logic [31:0] vj,
                      input logic [31:0] vk, input logic [31:0] imm,
                      input logic [31:0] pc, input logic [ROB_LOG-1:0] dest);
    exp_t e;
    e.op = op; e.vj = vj; e.vk = vk; e.imm = imm; e.pc = pc; e.dest = dest;
    sb.push_back(e);
  endtask

  task automatic valid_is(input string tag, input logic exp);
    @(negedge clk_in);
    check(tag, 32'(RS_valid), 32'(exp));
  endtask

  // Blocked-on-Qj dispatch, then a broadcast on the selected bus(es).
  task automatic wake_case(input string tag, input logic [ROB_LOG-1:0] rob,
                           input bit use_alu, input bit use_lsb,
                           input logic [31:0] alu_val, input logic [31:0] lsb_val,
                           input logic [31:0] exp_vj);
    disp(OP_SUB, 1'b1, rob, 32'h0BAD, 1'b0, 4'd0, 32'd1, 32'h10, 4'd5, 32'h104);
    tick(); idle();
    tick();
    @(negedge clk_in);
    check({tag, "_blocked"}, 32'(RS_valid), 32'd0);
    B_enable = use_alu; B_RobId = rob; B_value = alu_val;
    L_enable = use_lsb; L_RobId = rob; L_value = lsb_val;
    push(OP_SUB, exp_vj, 32'd1, 32'h10, 32'h104, 4'd5);
    tick(); idle();
    valid_is({tag, "_lat1"}, 1'b0);
    tick();
    valid_is({tag, "_lat2"}, 1'b1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; idle();
    disp(OP_NOP, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0);
    D_valid = 1'b0;
    #1 rst_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #2;
    check("rst_valid", 32'(RS_valid), 32'd0);
    check("rst_full",  32'(RS_full),  32'd0);
    check("rst_vj",    RS_Vj,         32'd0);
    check("rst_dest",  32'(RS_DestRob), 32'd0);
    rst_in = 1'b1;
    tick();

    // Ready dispatch: issue visible two edges after dispatch is driven.
    disp(OP_ADD, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7, 32'd0, 4'd3, 32'h100);
    push(OP_ADD, 32'd5, 32'd7, 32'd0, 32'h100, 4'd3);
    tick(); idle();
    valid_is("ready_lat1", 1'b0);
    tick();
    valid_is("ready_lat2", 1'b1);
    check("ready_full", 32'(RS_full), 32'd0);
    tick();
    valid_is("ready_freed", 1'b0);
    tick();

    // CDB wakeup on each bus, and the ALU bus winning a tag collision.
    wake_case("wake_alu", 4'd6, 1'b1, 1'b0, 32'h1234, 32'h0,    32'h1234);
    wake_case("wake_lsb", 4'd6, 1'b0, 1'b1, 32'h0,    32'h1234, 32'h1234);
    wake_case("wake_both", 4'd7, 1'b1, 1'b1, 32'hAAAA, 32'hBBBB, 32'hAAAA);

    // Same-cycle bypass from the LSB bus into Qk.
    disp(OP_BEQ, 1'b0, 4'd0, 32'd9, 1'b1, 4'd2, 32'd0, 32'd8, 4'd2, 32'h108);
    L_enable = 1'b1; L_RobId = 4'd2; L_value = 32'hDEAD;
    push(OP_BEQ, 32'd9, 32'hDEAD, 32'd8, 32'h108, 4'd2);
    tick(); idle();
    valid_is("bypass_lat1", 1'b0);
    tick();
    valid_is("bypass_lat2", 1'b1);
    tick();

    // Fill all 16 slots with entries blocked on tag == index.
    for (int i = 0; i < RS_SIZE; i++) begin
      disp(OP_ADD, 1'b1, ROB_LOG'(i), 32'd0, 1'b0, 4'd0, 32'(i), 32'd0,
           ROB_LOG'(i), 32'h200 + 32'(4 * i));
      tick();
    end
    idle();
    @(negedge clk_in);
    check("full_set", 32'(RS_full), 32'd1);
    // A ready op while full must be dropped (it would otherwise issue).
    disp(OP_JAL, 1'b0, 4'd0, 32'h77, 1'b0, 4'd0, 32'h88, 32'd0, 4'd15, 32'h300);
    tick(); idle();
    @(negedge clk_in);
    check("full_drop", 32'(RS_full), 32'd1);
    tick();
    valid_is("full_no_issue", 1'b0);
    // Wake entries 4 (ALU bus) and 9 (LSB bus) together.
    B_enable = 1'b1; B_RobId = 4'd4; B_value = 32'h44;
    L_enable = 1'b1; L_RobId = 4'd9; L_value = 32'h99;
    push(OP_ADD, 32'h44, 32'd4, 32'd0, 32'h210, 4'd4);
    push(OP_ADD, 32'h99, 32'd9, 32'd0, 32'h224, 4'd9);
    tick(); idle();
    valid_is("order_lat", 1'b0);
    check("order_still_full", 32'(RS_full), 32'd1);
    tick();
    valid_is("order_first", 1'b1);
    check("order_first_dest", 32'(RS_DestRob), 32'd4);
    check("full_fall", 32'(RS_full), 32'd0);
    tick();
    valid_is("order_second", 1'b1);
    check("order_second_dest", 32'(RS_DestRob), 32'd9);
    tick();
    valid_is("order_done", 1'b0);
    clear_in = 1'b1;
    tick(); idle();
    @(negedge clk_in);
    check("clear_empty", 32'(RS_full), 32'd0);
    tick();

    // Flush: five blocked entries plus one about to issue, and a dispatch
    // presented in the clear cycle.
    for (int i = 0; i < 5; i++) begin
      disp(OP_ADD, 1'b1, ROB_LOG'(10 + i), 32'd0, 1'b0, 4'd0, 32'd0, 32'd0,
           ROB_LOG'(i), 32'd0);
      tick();
    end
    disp(OP_ADD, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2, 32'd0, 4'd1, 32'h400);
    tick();
    idle();
    clear_in = 1'b1;
    disp(OP_SUB, 1'b0, 4'd0, 32'd3, 1'b0, 4'd0, 32'd4, 32'd0, 4'd2, 32'h404);
    tick(); idle();
    valid_is("flush_valid", 1'b0);
    check("flush_full", 32'(RS_full), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      valid_is("flush_quiet", 1'b0);
    end
    B_enable = 1'b1; B_RobId = 4'd10; B_value = 32'd1;
    tick(); idle();
    tick();
    valid_is("flush_gone", 1'b0);
    tick();

    // Freeze: A issues, then B is held while rdy_in is low.
    disp(OP_NOP, 1'b0, 4'd0, 32'h11, 1'b0, 4'd0, 32'h22, 32'h33, 4'd6, 32'h500);
    push(OP_NOP, 32'h11, 32'h22, 32'h33, 32'h500, 4'd6);
    tick();
    disp(OP_ADD, 1'b0, 4'd0, 32'h55, 1'b0, 4'd0, 32'h66, 32'h0, 4'd7, 32'h504);
    push(OP_ADD, 32'h55, 32'h66, 32'h0, 32'h504, 4'd7);
    tick(); idle();
    valid_is("frz_a", 1'b1);
    rdy_in = 1'b0;
    tick();
    valid_is("frz_forced0", 1'b0);
    tick();
    valid_is("frz_hold", 1'b0);
    rdy_in = 1'b1;
    tick();
    valid_is("frz_resume", 1'b1);
    tick();
    valid_is("frz_done", 1'b0);
    tick();

    // Asynchronous reset while an issue is on the outputs.
    disp(OP_ADD, 1'b1, 4'd3, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd8, 32'h600);
    tick();
    disp(OP_SUB, 1'b0, 4'd0, 32'h99, 1'b0, 4'd0, 32'h98, 32'h0, 4'd9, 32'h604);
    push(OP_SUB, 32'h99, 32'h98, 32'h0, 32'h604, 4'd9);
    tick(); idle();
    tick();
    valid_is("rst_pre", 1'b1);
    #2 rst_in = 1'b0;
    #1;
    check("rst_async_valid", 32'(RS_valid), 32'd0);
    check("rst_async_vj",    RS_Vj,         32'd0);
    check("rst_async_dest",  32'(RS_DestRob), 32'd0);
    tick();
    rst_in = 1'b1;
    B_enable = 1'b1; B_RobId = 4'd3; B_value = 32'd1;
    tick(); idle();
    tick();
    valid_is("rst_lost", 1'b0);
    check("rst_full", 32'(RS_full), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
